// File: rtl/r4_otfc.sv
// r4_otfc: radix-4 on-the-fly conversion unit for the fractional divider.
//
// Builds the binary quotient one signed radix-4 digit per iteration. It keeps two
// registers, Q and QM = Q - ulp, so no carry-propagate addition is needed. After the
// last digit, the final remainder sign selects Q or QM. The result is then offered on
// a valid/ready handshake.
//
// Parameters:
//   QUO_W          quotient width in bits; must be even and >= 4. Iterations = QUO_W/2.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   start_i        begin a new conversion (accepted only in IDLE)
//   quo_dig_vld_i  quo_dig_i valid this cycle
//   quo_dig_i      one-hot digit: [4]=-2, [3]=-1, [2]=0, [1]=+1, [0]=+2
//   rem_vld_i      final remainder sign valid (sampled only while waiting for it)
//   rem_neg_i      final remainder is negative, so select QM
//   quo_rdy_i      downstream accepts quo_o
//   quo_o          corrected quotient (registered)
//   quo_vld_o      quo_o valid (registered)
//   busy_o         high in every state except IDLE
//   err_o          sticky illegal-digit flag
//
// Optional feature:
//   R4_OTFC_ONEHOT_CHECK_EN  when defined, a digit that is not exactly one-hot sets err_o
//                            and leaves Q/QM unchanged, but still counts as an iteration.
//                            When undefined, err_o is 0 and the digit decodes by priority
//                            (bit [4] highest; all-zero means 0).

module r4_otfc #(
    parameter int unsigned QUO_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             quo_dig_vld_i,
    input  logic [4:0]       quo_dig_i,
    input  logic             rem_vld_i,
    input  logic             rem_neg_i,
    input  logic             quo_rdy_i,
    output logic [QUO_W-1:0] quo_o,
    output logic             quo_vld_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned ITER_NUM = QUO_W / 2;
    localparam int unsigned CNT_W    = $clog2(ITER_NUM + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_NUM - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StWaitRem,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        DigPos2,
        DigPos1,
        DigZero,
        DigNeg1,
        DigNeg2
    } dig_e;

    state_e           state_q;
    logic [QUO_W-1:0] q_q;
    logic [QUO_W-1:0] qm_q;
    logic [QUO_W-1:0] q_nxt;
    logic [QUO_W-1:0] qm_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [QUO_W-1:0] quo_q;
    logic             quo_vld_q;
    dig_e             dig_val;

`ifdef R4_OTFC_ONEHOT_CHECK_EN
    logic             dig_bad;
    logic             err_q;
`endif

    // Digit decode.
    always_comb begin
        dig_val = DigZero;
`ifdef R4_OTFC_ONEHOT_CHECK_EN
        dig_bad = 1'b0;
        case (quo_dig_i)
            5'b00001: dig_val = DigPos2;
            5'b00010: dig_val = DigPos1;
            5'b00100: dig_val = DigZero;
            5'b01000: dig_val = DigNeg1;
            5'b10000: dig_val = DigNeg2;
            default:  dig_bad = 1'b1;
        endcase
`else
        // Priority decode; bit [4] wins and an all-zero digit falls through to 0.
        if (quo_dig_i[4]) begin
            dig_val = DigNeg2;
        end else if (quo_dig_i[3]) begin
            dig_val = DigNeg1;
        end else if (quo_dig_i[2]) begin
            dig_val = DigZero;
        end else if (quo_dig_i[1]) begin
            dig_val = DigPos1;
        end else if (quo_dig_i[0]) begin
            dig_val = DigPos2;
        end else begin
            dig_val = DigZero;
        end
`endif
    end

    // On-the-fly update. Both results come from the pre-update Q/QM. The shift drops
    // the top two bits, so only the low QUO_W bits are kept.
    always_comb begin
        q_nxt  = q_q;
        qm_nxt = qm_q;
        case (dig_val)
            DigPos2: begin
                q_nxt  = {q_q[QUO_W-3:0], 2'b10};
                qm_nxt = {q_q[QUO_W-3:0], 2'b01};
            end
            DigPos1: begin
                q_nxt  = {q_q[QUO_W-3:0], 2'b01};
                qm_nxt = {q_q[QUO_W-3:0], 2'b00};
            end
            DigZero: begin
                q_nxt  = {q_q[QUO_W-3:0], 2'b00};
                qm_nxt = {qm_q[QUO_W-3:0], 2'b11};
            end
            DigNeg1: begin
                q_nxt  = {qm_q[QUO_W-3:0], 2'b11};
                qm_nxt = {qm_q[QUO_W-3:0], 2'b10};
            end
            DigNeg2: begin
                q_nxt  = {qm_q[QUO_W-3:0], 2'b10};
                qm_nxt = {qm_q[QUO_W-3:0], 2'b01};
            end
            default: begin
                q_nxt  = q_q;
                qm_nxt = qm_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            q_q       <= '0;
            qm_q      <= '1;
            cnt_q     <= '0;
            quo_q     <= '0;
            quo_vld_q <= 1'b0;
`ifdef R4_OTFC_ONEHOT_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        q_q     <= '0;
                        qm_q    <= '1;
                        cnt_q   <= '0;
`ifdef R4_OTFC_ONEHOT_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    if (quo_dig_vld_i) begin
`ifdef R4_OTFC_ONEHOT_CHECK_EN
                        // A bad digit still consumes an iteration so the loop stays aligned
                        // with the remainder datapath.
                        if (dig_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            q_q  <= q_nxt;
                            qm_q <= qm_nxt;
                        end
`else
                        q_q  <= q_nxt;
                        qm_q <= qm_nxt;
`endif
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= StWaitRem;
                        end
                    end
                end
                StWaitRem: begin
                    if (rem_vld_i) begin
                        // A negative final remainder means the quotient overshot by one ulp.
                        quo_q     <= rem_neg_i ? qm_q : q_q;
                        quo_vld_q <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (quo_rdy_i) begin
                        quo_vld_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign quo_o     = quo_q;
    assign quo_vld_o = quo_vld_q;
    assign busy_o    = (state_q != StIdle);

`ifdef R4_OTFC_ONEHOT_CHECK_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_r4_otfc.sv
// Scoreboard bench for r4_otfc at QUO_W=8. The stimulus pushes the expected quotient
// and error flag for each conversion. A negedge monitor checks quo_o against the queue
// head while quo_vld_o is high, and pops the entry on the handshake.

module tb_r4_otfc;

    localparam int unsigned W = 8;

    localparam logic [4:0] D_P2 = 5'b00001;
    localparam logic [4:0] D_P1 = 5'b00010;
    localparam logic [4:0] D_Z  = 5'b00100;
    localparam logic [4:0] D_N1 = 5'b01000;
    localparam logic [4:0] D_N2 = 5'b10000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         quo_dig_vld_i;
    logic [4:0]   quo_dig_i;
    logic         rem_vld_i;
    logic         rem_neg_i;
    logic         quo_rdy_i;
    logic [W-1:0] quo_o;
    logic         quo_vld_o;
    logic         busy_o;
    logic         err_o;

    typedef struct {
        logic [W-1:0] quo;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    r4_otfc #(.QUO_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .quo_dig_vld_i (quo_dig_vld_i),
        .quo_dig_i     (quo_dig_i),
        .rem_vld_i     (rem_vld_i),
        .rem_neg_i     (rem_neg_i),
        .quo_rdy_i     (quo_rdy_i),
        .quo_o         (quo_o),
        .quo_vld_o     (quo_vld_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: outputs must match the queue head whenever valid, then pop on handshake.
    always @(negedge clk) begin
        if (!rst && quo_vld_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_quo_vld", 32'(quo_vld_o), 32'd0);
            end else begin
                check("quo_o", 32'(quo_o), 32'(exp_q[0].quo));
                if (quo_rdy_i) begin
                    check("err_o", 32'(err_o), 32'(exp_q[0].err));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion. stall=1 inserts i idle cycles before digit i. noise=1 drives
    // inputs that the current state must ignore.
    task automatic run_conv(input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2,
                            input logic [4:0] d3, input bit stall, input bit rneg,
                            input logic [W-1:0] eq, input bit eerr, input int rdy_wait,
                            input bit noise);
        logic [4:0] digs [4];
        exp_t e;
        digs[0] = d0; digs[1] = d1; digs[2] = d2; digs[3] = d3;
        e.quo = eq;
        e.err = eerr;
        exp_q.push_back(e);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("err_clear_on_start", 32'(err_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < (stall ? i : 0); s++) begin
                quo_dig_vld_i = 1'b0;
                quo_dig_i     = D_N2;
                tick();
            end
            start_i       = noise;
            rem_vld_i     = noise;
            rem_neg_i     = ~rneg;
            quo_dig_vld_i = 1'b1;
            quo_dig_i     = digs[i];
            if (i == 3) begin
                rem_vld_i = 1'b1;
                rem_neg_i = rneg;
            end
            tick();
            quo_dig_vld_i = 1'b0;
            start_i       = 1'b0;
        end
        check("vld_low_in_wait_rem", 32'(quo_vld_o), 32'd0);
        rem_vld_i     = 1'b1;
        rem_neg_i     = rneg;
        quo_dig_vld_i = noise;
        quo_dig_i     = D_N2;
        tick();
        rem_vld_i     = 1'b0;
        quo_dig_vld_i = 1'b0;
        check("vld_after_rem", 32'(quo_vld_o), 32'd1);
        check("busy_in_done", 32'(busy_o), 32'd1);
        for (int k = 0; k < rdy_wait; k++) begin
            quo_rdy_i = 1'b0;
            start_i   = noise;
            tick();
            start_i = 1'b0;
            check("vld_held_while_stalled", 32'(quo_vld_o), 32'd1);
        end
        quo_rdy_i = 1'b1;
        tick();
        quo_rdy_i = 1'b0;
        check("vld_drop_after_hs", 32'(quo_vld_o), 32'd0);
        check("busy_low_in_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start_i       = 1'b0;
        quo_dig_vld_i = 1'b0;
        quo_dig_i     = 5'b0;
        rem_vld_i     = 1'b0;
        rem_neg_i     = 1'b0;
        quo_rdy_i     = 1'b0;
        repeat (3) tick();
        check("rst_quo", 32'(quo_o), 32'd0);
        check("rst_vld", 32'(quo_vld_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        tick();

        // +2,+1,0,-1: Q/QM 02/01, 09/08, 24/23, 8F/8E.
        run_conv(D_P2, D_P1, D_Z, D_N1, 1'b0, 1'b0, 8'h8F, 1'b0, 0, 1'b0);
        // Back-to-back, negative remainder selects QM.
        run_conv(D_P2, D_P1, D_Z, D_N1, 1'b0, 1'b1, 8'h8E, 1'b0, 0, 1'b0);
        // Four -2 digits: QM path each step, Q=0x56, QM=0x55.
        run_conv(D_N2, D_N2, D_N2, D_N2, 1'b0, 1'b0, 8'h56, 1'b0, 0, 1'b0);
        // Stalls and a held-off handshake, with ignored inputs toggling.
        run_conv(D_P2, D_P1, D_Z, D_N1, 1'b1, 1'b0, 8'h8F, 1'b0, 5, 1'b1);

        // Abort mid-ITER after two digits.
        start_i = 1'b1;
        tick();
        start_i       = 1'b0;
        quo_dig_vld_i = 1'b1;
        quo_dig_i     = D_P2;
        tick();
        quo_dig_i = D_P1;
        tick();
        quo_dig_vld_i = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_quo", 32'(quo_o), 32'd0);
        check("midrst_vld", 32'(quo_vld_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        tick();
        // Q: 01, 05, 15, 55.
        run_conv(D_P1, D_P1, D_P1, D_P1, 1'b0, 1'b0, 8'h55, 1'b0, 0, 1'b0);

`ifdef R4_OTFC_ONEHOT_CHECK_EN
        // Bad digit leaves Q=02/QM=01; then 0,0 give Q=08, then Q=20.
        run_conv(D_P2, 5'b00011, D_Z, D_Z, 1'b0, 1'b0, 8'h20, 1'b1, 2, 1'b0);
`else
        // 5'b00011 decodes as +1: Q 02, 09, 24, 90.
        run_conv(D_P2, 5'b00011, D_Z, D_Z, 1'b0, 1'b0, 8'h90, 1'b0, 2, 1'b0);
`endif
        // A fresh start clears any sticky error.
        run_conv(D_Z, D_Z, D_Z, D_P1, 1'b0, 1'b0, 8'h01, 1'b0, 0, 1'b0);

        begin
            int budget = 50;
            while (exp_q.size() != 0 && budget > 0) begin
                tick();
                budget--;
            end
            check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
